// File: rtl/wb_efuse_array_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_efuse_array_if
// Description : Bus bundle for the eFuse Wishbone front end. Carries the
//               system-master Wishbone port (wbm_*) and the fanned-out
//               eFuse slave ports (wbs_*).
//   master modport : environment view (drives master requests and slave
//                    responses, observes acks and slave strobes)
//   slave modport  : front-end view (used by wb_efuse_array)
//   Signals: wbm_adr_i/dat_i/we_i/sel_i/stb_i/cyc_i, wbm_dat_o/ack_o,
//            wbs_adr_o/dat_o/we_o/sel_o, wbs_cyc_o/stb_o (per bank),
//            wbs_dat_i (32 bits per bank), wbs_ack_i (per bank)
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_efuse_array_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BANKS  = 4
);
    logic [ADDR_WIDTH-1:0]           wbm_adr_i;
    logic [DATA_WIDTH-1:0]           wbm_dat_i;
    logic [DATA_WIDTH-1:0]           wbm_dat_o;
    logic                            wbm_we_i;
    logic [3:0]                      wbm_sel_i;
    logic                            wbm_stb_i;
    logic                            wbm_cyc_i;
    logic                            wbm_ack_o;

    logic [31:0]                     wbs_adr_o;
    logic [DATA_WIDTH-1:0]           wbs_dat_o;
    logic                            wbs_we_o;
    logic [3:0]                      wbs_sel_o;
    logic [NUM_BANKS-1:0]            wbs_cyc_o;
    logic [NUM_BANKS-1:0]            wbs_stb_o;
    logic [DATA_WIDTH*NUM_BANKS-1:0] wbs_dat_i;
    logic [NUM_BANKS-1:0]            wbs_ack_i;

    modport master (
        output wbm_adr_i, wbm_dat_i, wbm_we_i, wbm_sel_i, wbm_stb_i, wbm_cyc_i,
        input  wbm_dat_o, wbm_ack_o,
        input  wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_sel_o, wbs_cyc_o, wbs_stb_o,
        output wbs_dat_i, wbs_ack_i
    );

    modport slave (
        input  wbm_adr_i, wbm_dat_i, wbm_we_i, wbm_sel_i, wbm_stb_i, wbm_cyc_i,
        output wbm_dat_o, wbm_ack_o,
        output wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_sel_o, wbs_cyc_o, wbs_stb_o,
        input  wbs_dat_i, wbs_ack_i
    );
endinterface
`default_nettype wire

// File: rtl/wb_efuse_array.sv
`default_nettype none
// ============================================================================
// Module      : wb_efuse_array
// Description : Wishbone front end for a bank of eFuse macros. Decodes one
//               master port onto NUM_BANKS eFuse slave ports plus a local
//               control page (LOCK, STATUS). Adds sticky per-bank program
//               locks, gated macro write enables and an optional slave
//               response timeout.
//   wb_clk_i     : clock
//   wb_rst_i     : synchronous active-high reset
//   bus          : wb_efuse_array_if.slave (master port + per-bank slaves)
//   npor_i       : active-low power-on reset, qualifies programming
//   fuse_wr_en_o : per-macro write enable, npor_i & ~lock (combinational)
// Build option: define EFUSE_WB_TIMEOUT_EN to compile in the timeout counter
//               and STATUS.TIMEOUT_ERR; otherwise FWD waits indefinitely.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_efuse_array #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int NUM_BANKS    = 4,
    parameter int BANK_SEL_LSB = 12,
    parameter int TIMEOUT      = 255
) (
    input  wire logic             wb_clk_i,
    input  wire logic             wb_rst_i,
    wb_efuse_array_if.slave       bus,
    input  wire logic             npor_i,
    output logic [NUM_BANKS-1:0]  fuse_wr_en_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] c_ctrl_idx   = 4'(NUM_BANKS);
    localparam logic [1:0] c_off_lock   = 2'd0;
    localparam logic [1:0] c_off_status = 2'd1;

    state_t                  r_state;
    state_t                  w_next_state;

    logic [BANK_SEL_LSB-1:0] r_adr;
    logic [DATA_WIDTH-1:0]   r_wdat;
    logic [DATA_WIDTH-1:0]   r_rdat;
    logic                    r_we;
    logic [3:0]              r_sel;
    logic [3:0]              r_bank;
    logic [NUM_BANKS-1:0]    r_lock;
    logic                    r_to_err;
    logic                    r_wrb_err;
    logic [2:0]              r_last_err;

    logic                    w_req;
    logic [3:0]              w_bidx;
    logic [1:0]              w_off;
    logic                    w_mapped;
    logic                    w_is_ctrl;
    logic [NUM_BANKS-1:0]    w_req_oh;
    logic [NUM_BANKS-1:0]    w_cur_oh;
    logic                    w_lock_hit;
    logic                    w_slv_ack;
    logic                    w_to_hit;
    logic                    w_accept;
    logic                    w_blocked;
    logic                    w_fwd_ack;
    logic                    w_timeout;
    logic                    w_ctrl_wr;
    logic [DATA_WIDTH-1:0]   w_slv_rdata;
    logic [DATA_WIDTH-1:0]   w_ctrl_rdata;
    logic [DATA_WIDTH-1:0]   w_status;
    logic                    w_unused_adr;

    assign w_req     = bus.wbm_cyc_i & bus.wbm_stb_i;
    assign w_bidx    = bus.wbm_adr_i[BANK_SEL_LSB+3:BANK_SEL_LSB];
    assign w_off     = bus.wbm_adr_i[3:2];
    assign w_mapped  = (w_bidx < c_ctrl_idx);
    assign w_is_ctrl = (w_bidx == c_ctrl_idx);

    // Address bits above the bank index only alias the decoded windows.
    assign w_unused_adr = ^bus.wbm_adr_i[ADDR_WIDTH-1:BANK_SEL_LSB+4];

    // One-hot views of the incoming bank index and of the latched one.
    generate
        for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank_dec
            assign w_req_oh[i] = (w_bidx == 4'(i));
            assign w_cur_oh[i] = (r_bank == 4'(i));
        end
    endgenerate

    assign w_lock_hit = |(w_req_oh & r_lock);
    // Acks from banks other than the latched one are masked off here.
    assign w_slv_ack  = |(w_cur_oh & bus.wbs_ack_i);

    always_comb begin
        w_slv_rdata = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (w_cur_oh[i]) begin
                w_slv_rdata = bus.wbs_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_status = {{(DATA_WIDTH-7){1'b0}}, r_last_err, 2'b00, r_wrb_err, r_to_err};

    always_comb begin
        w_ctrl_rdata = '0;
        case (w_off)
            c_off_lock:   w_ctrl_rdata[NUM_BANKS-1:0] = r_lock;
            c_off_status: w_ctrl_rdata = w_status;
            default:      w_ctrl_rdata = '0;
        endcase
    end

    // Control-page writes act only on byte lane 0.
    assign w_ctrl_wr = w_accept & w_is_ctrl & bus.wbm_we_i & bus.wbm_sel_i[0];

`ifdef EFUSE_WB_TIMEOUT_EN
    logic [15:0] r_to_cnt;

    // Cleared when a request is accepted, so it reads 0 in the first FWD cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_to_cnt <= '0;
        end else if (w_accept) begin
            r_to_cnt <= '0;
        end else if (r_state == FWD) begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end
    end

    assign w_to_hit = (r_to_cnt == 16'(TIMEOUT));
`else
    logic [15:0] w_unused_timeout;

    assign w_unused_timeout = 16'(TIMEOUT);
    assign w_to_hit         = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_blocked    = 1'b0;
        w_fwd_ack    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_accept = 1'b1;
                    if (w_mapped && !(bus.wbm_we_i && w_lock_hit)) begin
                        w_next_state = FWD;
                    end else begin
                        // Locked-bank write, control page or unmapped: answer locally.
                        w_next_state = RESP;
                        w_blocked    = w_mapped;
                    end
                end
            end
            FWD: begin
                if (!bus.wbm_cyc_i) begin
                    w_next_state = IDLE;
                end else if (w_slv_ack) begin
                    w_next_state = RESP;
                    w_fwd_ack    = 1'b1;
                end else if (w_to_hit) begin
                    w_next_state = RESP;
                    w_timeout    = 1'b1;
                end
            end
            RESP: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_adr      <= '0;
            r_wdat     <= '0;
            r_rdat     <= '0;
            r_we       <= 1'b0;
            r_sel      <= '0;
            r_bank     <= '0;
            r_lock     <= '0;
            r_to_err   <= 1'b0;
            r_wrb_err  <= 1'b0;
            r_last_err <= '0;
        end else begin
            if (w_accept) begin
                r_adr  <= bus.wbm_adr_i[BANK_SEL_LSB-1:0];
                r_wdat <= bus.wbm_dat_i;
                r_we   <= bus.wbm_we_i;
                r_sel  <= bus.wbm_sel_i;
                r_bank <= w_bidx;
                if (w_next_state == RESP) begin
                    r_rdat <= (w_is_ctrl && !bus.wbm_we_i) ? w_ctrl_rdata : '0;
                end
            end
            if (w_fwd_ack) begin
                r_rdat <= w_slv_rdata;
            end
            if (w_timeout) begin
                r_rdat <= '1;
            end

            if (w_ctrl_wr && (w_off == c_off_lock)) begin
                r_lock <= r_lock | bus.wbm_dat_i[NUM_BANKS-1:0];
            end
            if (w_ctrl_wr && (w_off == c_off_status)) begin
                if (bus.wbm_dat_i[0]) r_to_err  <= 1'b0;
                if (bus.wbm_dat_i[1]) r_wrb_err <= 1'b0;
            end
            // Error sets come last so they win over a coincident W1C.
            if (w_blocked) begin
                r_wrb_err  <= 1'b1;
                r_last_err <= w_bidx[2:0];
            end
            if (w_timeout) begin
                r_to_err   <= 1'b1;
                r_last_err <= r_bank[2:0];
            end
        end
    end

    assign bus.wbm_ack_o = (r_state == RESP);
    assign bus.wbm_dat_o = r_rdat;
    assign bus.wbs_adr_o = {{(32-BANK_SEL_LSB){1'b0}}, r_adr};
    assign bus.wbs_dat_o = r_wdat;
    assign bus.wbs_we_o  = r_we;
    assign bus.wbs_sel_o = r_sel;
    assign bus.wbs_cyc_o = (r_state == FWD) ? w_cur_oh : '0;
    assign bus.wbs_stb_o = (r_state == FWD) ? w_cur_oh : '0;

    assign fuse_wr_en_o = {NUM_BANKS{npor_i}} & ~r_lock;

endmodule
`default_nettype wire

// File: tb/tb_wb_efuse_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_efuse_array
// Description : Self-checking bench for wb_efuse_array. Directed requests
//               push expected {data, ack cycle} into a scoreboard queue; a
//               monitor pops and compares on every wbm_ack_o. A per-bank
//               slave model acks after a programmable number of strobe
//               cycles (-1 = never).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_efuse_array;

    localparam int NB = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          npor;
    logic [NB-1:0] fuse_wr_en;

    wb_efuse_array_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_BANKS(NB)) bus ();

    wb_efuse_array #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (32),
        .NUM_BANKS    (NB),
        .BANK_SEL_LSB (12),
        .TIMEOUT      (TO)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .bus          (bus),
        .npor_i       (npor),
        .fuse_wr_en_o (fuse_wr_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dat;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc_cnt  = 0;
    int          bank_delay [NB];
    logic [31:0] bank_rdata [NB];
    int          sw_cnt     [NB];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Slave model: ack in the (delay+1)-th consecutive strobe cycle.
    generate
        for (genvar g = 0; g < NB; g++) begin : g_slv_dat
            assign bus.wbs_dat_i[g*32 +: 32] = bank_rdata[g];
        end
    endgenerate

    always @(negedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (bus.wbs_stb_o[i]) sw_cnt[i] = sw_cnt[i] + 1;
            else                  sw_cnt[i] = 0;
            bus.wbs_ack_i[i] = (bank_delay[i] >= 0) && bus.wbs_stb_o[i] &&
                               (sw_cnt[i] == bank_delay[i] + 1);
        end
    end

    // Monitor / scoreboard checker.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.wbm_ack_o) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_ack: ack in cycle %0d with data 0x%08h, required no ack",
                         cyc_cnt, bus.wbm_dat_o);
            end else begin
                e = sb_q.pop_front();
                check({e.name, "_cycle"}, cyc_cnt, e.cyc);
                check({e.name, "_data"}, bus.wbm_dat_o, e.dat);
            end
        end
    end

    task automatic idle_bus();
        bus.wbm_cyc_i = 1'b0;
        bus.wbm_stb_i = 1'b0;
        bus.wbm_we_i  = 1'b0;
        bus.wbm_sel_i = 4'h0;
        bus.wbm_adr_i = 32'h0;
        bus.wbm_dat_i = 32'h0;
    endtask

    // Called at a negedge; returns at the negedge of cycle 1.
    task automatic start(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] sel, input logic exp_ack,
                         input logic [31:0] exp_dat, input int lat, input string name);
        exp_t e;
        if (exp_ack) begin
            e.dat  = exp_dat;
            e.cyc  = cyc_cnt + lat;
            e.name = name;
            sb_q.push_back(e);
        end
        bus.wbm_adr_i = adr;
        bus.wbm_dat_i = dat;
        bus.wbm_we_i  = we;
        bus.wbm_sel_i = sel;
        bus.wbm_cyc_i = 1'b1;
        bus.wbm_stb_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic finish_req(input string name);
        int n = 0;
        while (!bus.wbm_ack_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.wbm_ack_o) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_ack_wait: no ack within 100 cycles, required an ack", name);
        end
        idle_bus();
        @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] adr, input logic [31:0] exp_dat, input int lat,
                      input string name);
        start(adr, 1'b0, 32'h0, 4'hF, 1'b1, exp_dat, lat, name);
        finish_req(name);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                      input string name);
        start(adr, 1'b1, dat, sel, 1'b1, 32'h0, 1, name);
        finish_req(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst  = 1'b1;
        npor = 1'b1;
        idle_bus();
        bank_rdata[0] = 32'h0BAD_F00D; bank_delay[0] = 1;
        bank_rdata[1] = 32'h1111_1111; bank_delay[1] = 0;
        bank_rdata[2] = 32'hA5A5_1234; bank_delay[2] = 3;
        bank_rdata[3] = 32'h3333_3333; bank_delay[3] = -1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_ack",    32'(bus.wbm_ack_o), 32'h0);
        check("rst_dat",    bus.wbm_dat_o,      32'h0);
        check("rst_cyc",    32'(bus.wbs_cyc_o), 32'h0);
        check("rst_stb",    32'(bus.wbs_stb_o), 32'h0);
        check("rst_adr",    bus.wbs_adr_o,      32'h0);
        check("rst_fuseen", 32'(fuse_wr_en),    32'hF);

        // Forwarded read, slave acks in its 4th strobe cycle
        start(32'h0000_2010, 1'b0, 32'h0, 4'hF, 1'b1, 32'hA5A5_1234, 5, "t1_rd_bank2");
        check("t1_stb", 32'(bus.wbs_stb_o), 32'h4);
        check("t1_cyc", 32'(bus.wbs_cyc_o), 32'h4);
        check("t1_adr", bus.wbs_adr_o,      32'h10);
        finish_req("t1_rd_bank2");

        // Lock bank 1, blocked write, STATUS
        wr(32'h0000_4000, 32'h2, 4'hF, "t2_lock_wr");
        check("t2_fuseen", 32'(fuse_wr_en), 32'hD);
        start(32'h0000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0, 1, "t2_blocked_wr");
        check("t2_blocked_stb", 32'(bus.wbs_stb_o), 32'h0);
        finish_req("t2_blocked_wr");
        rd(32'h0000_4004, 32'h12, 1, "t2_status");
        rd(32'h0000_4000, 32'h2,  1, "t2_lock_rd");
        wr(32'h0000_4000, 32'h1, 4'b1110, "t2_lock_nosel");
        rd(32'h0000_4000, 32'h2,  1, "t2_lock_sel_rd");
        wr(32'h0000_4004, 32'h2, 4'hF, "t2_status_w1c");
        rd(32'h0000_4004, 32'h10, 1, "t2_status_clr");

`ifdef EFUSE_WB_TIMEOUT_EN
        // Bank 3 never acks
        start(32'h0000_3000, 1'b0, 32'h0, 4'hF, 1'b1, 32'hFFFF_FFFF, TO + 2, "t3_timeout");
        check("t3_stb", 32'(bus.wbs_stb_o), 32'h8);
        finish_req("t3_timeout");
        rd(32'h0000_4004, 32'h31, 1, "t3_status");
        wr(32'h0000_4004, 32'h1, 4'hF, "t3_status_w1c");
        rd(32'h0000_4004, 32'h30, 1, "t3_status_clr");
`endif

        // Master abort in FWD cycle 2
        bank_delay[0] = -1;
        start(32'h0000_0000, 1'b0, 32'h0, 4'hF, 1'b0, 32'h0, 0, "t4_abort");
        check("t4_cyc_fwd", 32'(bus.wbs_cyc_o), 32'h1);
        @(negedge clk);
        idle_bus();
        @(negedge clk);
        check("t4_cyc_drop", 32'(bus.wbs_cyc_o), 32'h0);
        check("t4_stb_drop", 32'(bus.wbs_stb_o), 32'h0);
        repeat (3) @(negedge clk);
        bank_delay[0] = 1;
        start(32'h0000_0008, 1'b0, 32'h0, 4'hF, 1'b1, 32'h0BAD_F00D, 3, "t4_after_abort");
        check("t4_adr", bus.wbs_adr_o, 32'h8);
        finish_req("t4_after_abort");

        // Unmapped, reserved offsets, npor gating
        rd(32'h0000_6010, 32'h0, 1, "t5_unmapped_rd");
        wr(32'h0000_6000, 32'hFFFF_FFFF, 4'hF, "t5_unmapped_wr");
        rd(32'h0000_4000, 32'h2, 1, "t5_lock_rd");
        rd(32'h0000_400C, 32'h0, 1, "t5_rsvd_rd");
        wr(32'h0000_4008, 32'hF, 4'hF, "t5_rsvd_wr");
        rd(32'h0000_4000, 32'h2, 1, "t5_lock_kept");
        npor = 1'b0;
        @(negedge clk);
        check("t5_npor_low", 32'(fuse_wr_en), 32'h0);
        npor = 1'b1;
        @(negedge clk);
        check("t5_npor_high", 32'(fuse_wr_en), 32'hD);

        // Reset during FWD with all banks locked
        wr(32'h0000_4000, 32'hF, 4'hF, "t6_lock_all");
        check("t6_fuseen_locked", 32'(fuse_wr_en), 32'h0);
        rd(32'h0000_4000, 32'hF, 1, "t6_lock_rd");
        bank_delay[2] = -1;
        start(32'h0000_2044, 1'b0, 32'h0, 4'hF, 1'b0, 32'h0, 0, "t6_rst_fwd");
        check("t6_stb_fwd", 32'(bus.wbs_stb_o), 32'h4);
        rst = 1'b1;
        idle_bus();
        @(negedge clk);
        check("t6_ack", 32'(bus.wbm_ack_o), 32'h0);
        check("t6_dat", bus.wbm_dat_o,      32'h0);
        check("t6_cyc", 32'(bus.wbs_cyc_o), 32'h0);
        check("t6_stb", 32'(bus.wbs_stb_o), 32'h0);
        check("t6_adr", bus.wbs_adr_o,      32'h0);
        rst = 1'b0;
        @(negedge clk);
        rd(32'h0000_4000, 32'h0, 1, "t6_lock_after_rst");
        check("t6_fuseen_after_rst", 32'(fuse_wr_en), 32'hF);

        repeat (5) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_efuse_array.md
# wb_efuse_array

Parametrised Wishbone front end for a bank of eFuse macros. It decodes one master Wishbone port onto `NUM_BANKS` eFuse slave ports plus one local control page. It adds per-bank sticky program locks, gated write enables to each macro, and a slave-response timeout with a sticky error status. It sits between the system Wishbone master and the eFuse memory wrappers.

## Interface

Parameters:
- `DATA_WIDTH`, 32, data bus width; 32 is the only supported value.
- `ADDR_WIDTH`, 32, master address width.
- `NUM_BANKS`, 4, number of eFuse slave ports (1..8).
- `BANK_SEL_LSB`, 12, lowest address bit of the bank index; each bank window is 2^`BANK_SEL_LSB` bytes.
- `TIMEOUT`, 255, number of slave-wait cycles before a forced response (1..65535).

Ports:
- `wb_clk_i`  in  1  clock.
- `wb_rst_i`  in  1  synchronous active-high reset.
- `wbm_adr_i`  in  `ADDR_WIDTH`  master address.
- `wbm_dat_i`  in  32  master write data.
- `wbm_dat_o`  out  32  registered read data.
- `wbm_we_i`  in  1  write enable.
- `wbm_sel_i`  in  4  byte select.
- `wbm_stb_i`  in  1  strobe.
- `wbm_cyc_i`  in  1  cycle.
- `wbm_ack_o`  out  1  registered single-cycle acknowledge.
- `wbs_adr_o`  out  32  shared slave address: `wbm_adr_i[BANK_SEL_LSB-1:0]`, zero-extended.
- `wbs_dat_o`  out  32  shared slave write data.
- `wbs_we_o`  out  1  shared slave write enable.
- `wbs_sel_o`  out  4  shared slave byte select.
- `wbs_cyc_o`  out  `NUM_BANKS`  per-bank cycle.
- `wbs_stb_o`  out  `NUM_BANKS`  per-bank strobe.
- `wbs_dat_i`  in  `32*NUM_BANKS`  per-bank read data; bank i occupies bits [32i+31:32i].
- `wbs_ack_i`  in  `NUM_BANKS`  per-bank acknowledge.
- `npor_i`  in  1  active-low power-on reset; qualifies programming.
- `fuse_wr_en_o`  out  `NUM_BANKS`  per-macro write enable: `npor_i & ~lock[i]`. This output is combinational.

## Operation

- Bank index `b = wbm_adr_i[BANK_SEL_LSB+3:BANK_SEL_LSB]`.
  - `b < NUM_BANKS`: eFuse bank b.
  - `b == NUM_BANKS`: control page.
  - `b > NUM_BANKS`: unmapped.
- Control page registers, selected by offset bits [3:2]:
  - 0x0 LOCK[`NUM_BANKS`-1:0]: write-1-to-set. Bits stay set until `wb_rst_i`; writing 0 has no effect.
  - 0x4 STATUS:
    - bit0 TIMEOUT_ERR: sticky, write-1-to-clear.
    - bit1 WR_BLOCKED_ERR: sticky, write-1-to-clear.
    - bits[6:4] LAST_ERR_BANK: bank index of the most recent error; read-only.
  - 0x8 and 0xC: read 0; writes are ignored.
  - All control-page writes honour only `wbm_sel_i[0]`.
- FSM states: IDLE, FWD, RESP.
  - IDLE with `wbm_cyc_i & wbm_stb_i`: the request is latched.
    - Mapped bank, and either a read or an unlocked write: go to FWD.
    - Write to a locked bank: go to RESP. Nothing is forwarded, WR_BLOCKED_ERR is set, and LAST_ERR_BANK is set to b.
    - Control page or unmapped address: go to RESP with local data; unmapped reads return 0 and unmapped writes are dropped.
  - FWD: assert `wbs_cyc_o[b]` and `wbs_stb_o[b]`, with the shared slave signals held at the latched request. Other bank bits stay 0.
    - `wbs_ack_i[b]`: capture `wbs_dat_i` slice b and go to RESP.
    - Timeout counter reaches `TIMEOUT`: go to RESP with data 0xFFFF_FFFF. TIMEOUT_ERR is set and LAST_ERR_BANK is set to b.
    - `wbm_cyc_i` deasserted: master abort. Go to IDLE, drop the slave strobes, produce no ack.
  - RESP: `wbm_ack_o`=1 for exactly one cycle with `wbm_dat_o` valid, then go to IDLE.
- `wbs_ack_i` from a non-selected bank is ignored.
- Reset clears LOCK, STATUS, FSM, `wbm_ack_o`, `wbm_dat_o`, all `wbs_*` outputs and the timeout counter to 0.

## Timing

- Reset is synchronous and takes effect at the first rising edge with `wb_rst_i`=1. This also applies mid-transaction: the transaction is dropped and no ack is produced.
- Local or blocked access: request sampled at edge 0; ack is high in cycle 1.
- Forwarded access: slave strobe is high from cycle 1; a slave ack in cycle k gives `wbm_ack_o` in cycle k+1.
- Timeout: counter is cleared on FWD entry and increments each FWD cycle. With no slave ack, ack appears at cycle `TIMEOUT`+2.
- A new request can be accepted in the cycle immediately after the ack.
- A STATUS W1C write coinciding with a new error: the set takes priority.

## Configuration

- `EFUSE_WB_TIMEOUT_EN` defined: timeout counter and TIMEOUT_ERR logic are compiled in, as described above.
- `EFUSE_WB_TIMEOUT_EN` undefined: FWD waits indefinitely for slave ack or master abort, and STATUS bit0 reads 0.

## Test plan

- Read bank 2 offset 0x10 with slave ack after 3 cycles, data 0xA5A5_1234 -> `wbs_stb_o`=4'b0100, `wbs_adr_o`=0x10, `wbm_dat_o`=0xA5A5_1234, ack in cycle 5.
- Write LOCK=0x2 at control offset 0x0, then write to bank 1 -> no `wbs_stb_o[1]`, ack in cycle 1, `fuse_wr_en_o`=4'b1101, STATUS reads 0x12.
- Bank 3 never acks, `TIMEOUT`=8 -> ack at cycle 10, data 0xFFFF_FFFF, STATUS=0x31. Writing 0x1 to STATUS then reads back 0x30.
- Drop `wbm_cyc_i` in FWD cycle 2 -> `wbs_cyc_o`=0 next cycle, no `wbm_ack_o`, next request served normally.
- Read unmapped bank 6 -> ack cycle 1, data 0. `npor_i`=0 -> `fuse_wr_en_o`=0 regardless of LOCK.
- Assert `wb_rst_i` during FWD with LOCK=0xF -> all outputs 0, LOCK reads 0 after reset.
